// File: rtl/gf2m_exp_sequencer.sv
// Left-to-right square-and-multiply exponentiation R = A^E in GF(2^N).
// Drives one shared external combinational field multiplier through mul_a/mul_b/mul_m.
module gf2m_exp_sequencer #(
  parameter int N   = 233,
  parameter int E_W = 233,
  parameter int IW  = $clog2(E_W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [E_W-1:0] in_e,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_r,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [N-1:0]   mul_m
);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    r_reg, r_next;
  logic [N-1:0]    a_reg, a_next;
  logic [E_W-1:0]  e_reg, e_next;
  logic [IW-1:0]   idx_reg, idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      a_reg     <= '0;
      e_reg     <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      a_reg     <= a_next;
      e_reg     <= e_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    a_next     = a_reg;
    e_next     = e_reg;
    idx_next   = idx_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_r      = '0;
    mul_a      = '0;
    mul_b      = '0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_next     = in_a;
          e_next     = in_e;
          r_next     = {{(N-1){1'b0}}, 1'b1};
          idx_next   = IW'(E_W - 1);
          state_next = SQR;
        end
      end

      SQR: begin
        mul_a  = r_reg;
        mul_b  = r_reg;
        r_next = mul_m;
        // A set bit keeps idx for the following multiply step, which does the decrement.
        if (e_reg[idx_reg]) begin
          state_next = MUL;
        end else if (idx_reg == '0) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end

      MUL: begin
        mul_a  = r_reg;
        mul_b  = a_reg;
        r_next = mul_m;
        if (idx_reg == '0) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg - 1'b1;
          state_next = SQR;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        out_r     = r_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gf2m_exp_sequencer.sv
// Randomised scoreboard bench for gf2m_exp_sequencer; supplies the field multiplier
// and a right-to-left exponentiation reference model.
module tb_gf2m_exp_sequencer;
  localparam int N   = 233;
  localparam int E_W = 233;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   in_a = '0;
  logic [E_W-1:0] in_e = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N-1:0]   out_r;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [N-1:0]   mul_m;

  gf2m_exp_sequencer #(.N(N), .E_W(E_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_e(in_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Field product modulo x^233 + x^74 + 1, Horner over the bits of b.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] p;
    logic msb;
    p = '0;
    for (int i = N - 1; i >= 0; i--) begin
      msb = p[N-1];
      p = p << 1;
      p[74] = p[74] ^ msb;
      p[0]  = p[0] ^ msb;
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  assign mul_m = gf_mul(mul_a, mul_b);

  // Reference: right-to-left binary exponentiation.
  function automatic logic [N-1:0] pow_ref(input logic [N-1:0] a, input logic [E_W-1:0] e);
    logic [N-1:0] r;
    logic [N-1:0] b;
    r = '0;
    r[0] = 1'b1;
    b = a;
    for (int i = 0; i < E_W; i++) begin
      if (e[i]) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_n();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] a;
    logic         inv;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];

  // Monitor: pops on the first cycle of each result, then checks hold behaviour.
  logic         prev_valid = 1'b0;
  logic [N-1:0] held_r = '0;
  int           hs_cyc = -1;
  logic [N-1:0] one_v = N'(1);

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got out_r=%h with no request outstanding", out_r);
        end else begin
          e = q.pop_front();
          check("result", out_r, e.r);
          check("latency", N'(cyc - e.acc), N'(e.lat));
          if (e.inv) check("inverse_product", gf_mul(out_r, e.a), one_v);
          $display("txn acc=%0d lat=%0d out_r=%h", e.acc, cyc - e.acc, out_r);
        end
      end else if (out_valid && prev_valid) begin
        check("hold_out_r", out_r, held_r);
      end
      if (out_valid) begin
        check("done_in_ready", N'(in_ready), '0);
        check("done_mul_a", mul_a, '0);
        check("done_mul_b", mul_b, '0);
        if (out_ready) hs_cyc <= cyc + 1;
      end
      held_r     <= out_r;
      prev_valid <= out_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [E_W-1:0] e, input logic inv,
                       input logic [N-1:0] exp_r, output int acc);
    exp_t x;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = a;
    in_e = e;
    acc = -1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc + 1;
        check("idle_mul_a", mul_a, '0);
        x.r = exp_r; x.a = a; x.inv = inv; x.lat = E_W + $countones(e); x.acc = acc;
        q.push_back(x);
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 2000 cycles expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = rand_n();
    in_e = rand_n();
    @(negedge clk);
    if (acc >= 0) check("busy_in_ready", N'(in_ready), '0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2;
    logic [N-1:0] a, x74p1;
    logic [E_W-1:0] e;
    logic saw;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), '0);
    check("rst_out_r", out_r, '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);

    // Directed cases
    issue(N'(2), E_W'(3), 1'b0, N'(8), acc1);
    x74p1 = '0;
    x74p1[74] = 1'b1;
    x74p1[0] = 1'b1;
    issue(N'(2), E_W'(233), 1'b0, x74p1, acc1);
    issue(N'(5), '0, 1'b0, N'(1), acc1);
    issue('0, E_W'(1), 1'b0, '0, acc1);
    issue('0, '0, 1'b0, N'(1), acc1);
    issue(N'(1), rand_n(), 1'b0, N'(1), acc1);
    a = N'(32'hffffffff);
    e = '1;
    e[0] = 1'b0;
    issue(a, e, 1'b1, pow_ref(a, e), acc1);
    drain();

    // Randomised cases with mixed exponent densities
    for (int i = 0; i < 18; i++) begin
      a = rand_n();
      case (i % 3)
        0: e = rand_n();
        1: e = rand_n() & rand_n() & rand_n();
        default: e = rand_n() | rand_n();
      endcase
      issue(a, e, 1'b0, pow_ref(a, e), acc1);
    end
    drain();

    // Backpressure: hold result 10 cycles
    out_ready = 1'b0;
    a = rand_n();
    e = rand_n();
    issue(a, e, 1'b0, pow_ref(a, e), acc1);
    saw = 1'b0;
    for (int t = 0; t < 1000 && !saw; t++) begin
      @(negedge clk);
      saw = out_valid;
    end
    check("bp_reached_done", N'(saw), N'(1));
    repeat (10) @(negedge clk);
    check("bp_still_valid", N'(out_valid), N'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Abort mid-request via asynchronous reset
    a = rand_n();
    e = rand_n();
    issue(a, e, 1'b0, pow_ref(a, e), acc1);
    repeat (48) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_in_ready", N'(in_ready), N'(1));
    check("abort_mul_a", mul_a, '0);
    check("abort_out_valid", N'(out_valid), '0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    saw = 1'b0;
    repeat (600) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    check("abort_no_result", N'(saw), '0);

    // Back-to-back: second request accepted one cycle after first handshake
    a = rand_n();
    e = rand_n();
    issue(a, e, 1'b0, pow_ref(a, e), acc1);
    a = rand_n();
    e = rand_n();
    issue(a, e, 1'b0, pow_ref(a, e), acc2);
    check("b2b_accept_cycle", N'(acc2), N'(hs_cyc + 1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
